// File: rtl/cpu_out_port_if.sv
// cpu_out_port_if: CPU output-port handshake bundle.
// Covers host start, CPU word capture and the byte stream to the host.
interface cpu_out_port_if #(
    parameter int WIDTH = 24,
    parameter int ADDRW = 3
);
    logic             host_go;
    logic             start_io;
    logic             out_flag;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             overflow;
    logic [ADDRW:0]   count;

    modport master (
        output host_go, out_flag, out_data, byte_ready,
        input  start_io, byte_data, byte_valid, overflow, count
    );

    modport slave (
        input  host_go, out_flag, out_data, byte_ready,
        output start_io, byte_data, byte_valid, overflow, count
    );
endinterface

// File: rtl/cpu_out_port.sv
// cpu_out_port: start_io release, word FIFO and MSB-first byte serializer.
// Define CPU_OUT_CHECKSUM_EN to append an XOR checksum byte per word.
module cpu_out_port #(
    parameter int WIDTH       = 24,
    parameter int DEPTH       = 8,
    parameter int ADDRW       = 3,
    parameter int START_DELAY = 28
) (
    input logic           clock,
    input logic           reset,
    cpu_out_port_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
`ifdef CPU_OUT_CHECKSUM_EN
    localparam int NB = BYTES + 1;
`else
    localparam int NB = BYTES;
`endif
    localparam int IW = $clog2(NB + 1);
    localparam int CW = $clog2(START_DELAY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [CW-1:0]  DLY_END  = CW'(START_DELAY);
    localparam logic [ADDRW:0] CNT_FULL = (ADDRW + 1)'(DEPTH);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NB - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    dly_q, dly_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDRW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ADDRW:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [7:0]       fill;
    logic             hs, last_hs, pop, push;
`ifdef CPU_OUT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       csum_new;
`endif

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        start_d = start_q;
        case (state_q)
            S_IDLE: begin
                if (bus.host_go) begin
                    state_d = S_WAIT;
                    dly_d   = '0;
                end
            end
            S_WAIT: begin
                if (dly_q == DLY_END) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end else begin
                    dly_d = dly_q + CW'(1);
                end
            end
            S_RUN:   start_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign hs      = vld_q & bus.byte_ready;
    assign last_hs = hs && (idx_q == IDX_LAST);
    assign pop     = (cnt_q != '0) && (!vld_q || last_hs);
    assign push    = bus.out_flag && ((cnt_q != CNT_FULL) || pop);

`ifdef CPU_OUT_CHECKSUM_EN
    always_comb begin
        csum_new = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            csum_new = csum_new ^ mem_q[rd_q][i*8 +: 8];
        end
    end
    assign fill = csum_q;
`else
    assign fill = 8'h00;
`endif

    always_comb begin
        wr_d  = push ? wr_q + ADDRW'(1) : wr_q;
        rd_d  = pop ? rd_q + ADDRW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (ADDRW + 1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (ADDRW + 1)'(1);
        end
        ovf_d = ovf_q | (bus.out_flag & ~push);
    end

    // Left shift brings the next byte to the top; fill lands there after BYTES shifts.
    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        vld_d = vld_q;
`ifdef CPU_OUT_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (pop) begin
            sh_d  = mem_q[rd_q];
            idx_d = '0;
            vld_d = 1'b1;
`ifdef CPU_OUT_CHECKSUM_EN
            csum_d = csum_new;
`endif
        end else if (last_hs) begin
            vld_d = 1'b0;
        end else if (hs) begin
            sh_d  = {sh_q[WIDTH-9:0], fill};
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q] <= bus.out_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            start_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sh_q    <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
`ifdef CPU_OUT_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            start_q <= start_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
`ifdef CPU_OUT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.start_io   = start_q;
    assign bus.byte_data  = sh_q[WIDTH-1 -: 8];
    assign bus.byte_valid = vld_q;
    assign bus.overflow   = ovf_q;
    assign bus.count      = cnt_q;
endmodule

// File: tb/tb_cpu_out_port.sv
// tb_cpu_out_port: directed bench with a word/byte-stream reference model.
// Honours CPU_OUT_CHECKSUM_EN the same way as the design.
module tb_cpu_out_port;
    localparam int WIDTH = 24;
    localparam int DEPTH = 8;
    localparam int ADDRW = 3;
    localparam int BYTES = 3;
`ifdef CPU_OUT_CHECKSUM_EN
    localparam int NB = BYTES + 1;
    logic [7:0] e2 [NB] = '{8'h01, 8'h5F, 8'h90, 8'hCE};
    logic [7:0] e3 [NB] = '{8'h02, 8'hBF, 8'h20, 8'h9D};
    logic [7:0] e6 [NB] = '{8'h00, 8'h00, 8'h50, 8'h50};
`else
    localparam int NB = BYTES;
    logic [7:0] e2 [NB] = '{8'h01, 8'h5F, 8'h90};
    logic [7:0] e3 [NB] = '{8'h02, 8'hBF, 8'h20};
    logic [7:0] e6 [NB] = '{8'h00, 8'h00, 8'h50};
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    cpu_out_port_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) bus ();

    cpu_out_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW), .START_DELAY(28)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int         total = 0;
    int         bad = 0;
    bit         armed = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] seen [$];
    int         stored = 0;
    int         bpos = 0;
    int         hs_cnt = 0;
    bit         mov = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] word_byte(logic [23:0] w, int k);
        logic [7:0] x;
        x = 8'h00;
        if (k < BYTES) return 8'(w >> (8 * (BYTES - 1 - k)));
        for (int i = 0; i < BYTES; i++) x = x ^ 8'(w >> (8 * i));
        return x;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model: words held = accepted minus fully sent; a word is dropped only
    // when DEPTH+1 are held and none finishes on that edge.
    always @(negedge clock) begin
        bit done;
        done = 1'b0;
        if (reset) begin
            exp_q.delete();
            stored = 0;
            bpos   = 0;
            mov    = 1'b0;
        end else if (armed) begin
            chk("overflow", bus.overflow, mov);
            if (bus.byte_valid) begin
                chk("pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte_data", bus.byte_data, exp_q[0]);
                chk("count_busy", bus.count, stored - 1);
            end else begin
                chk("count_idle", bus.count, stored);
            end
            if (bus.byte_valid && bus.byte_ready && exp_q.size() != 0) begin
                seen.push_back(bus.byte_data);
                void'(exp_q.pop_front());
                hs_cnt++;
                bpos++;
                if (bpos == NB) begin
                    bpos = 0;
                    done = 1'b1;
                end
            end
            if (bus.out_flag) begin
                if (stored == DEPTH + 1 && !done) begin
                    mov = 1'b1;
                end else begin
                    for (int k = 0; k < NB; k++) exp_q.push_back(word_byte(bus.out_data, k));
                    stored++;
                end
            end
            if (done) stored--;
        end
    end

    initial begin
        int h0;
        bus.host_go    = 1'b0;
        bus.out_flag   = 1'b0;
        bus.out_data   = '0;
        bus.byte_ready = 1'b0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        armed = 1'b1;
        chk("rst_start_io", bus.start_io, 0);
        chk("rst_valid", bus.byte_valid, 0);
        chk("rst_data", bus.byte_data, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_overflow", bus.overflow, 0);

        bus.host_go = 1'b1;
        tick();
        bus.host_go = 1'b0;
        chk("start_wait0", bus.start_io, 0);
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk("start_delay", bus.start_io, k == 29);
        end
        for (int i = 0; i < 100; i++) begin
            bus.host_go = (i == 10);
            tick();
            chk("start_run", bus.start_io, 1);
        end
        bus.host_go = 1'b0;

        bus.byte_ready = 1'b1;
        bus.out_data   = 24'h015F90;
        bus.out_flag   = 1'b1;
        tick();
        bus.out_flag = 1'b0;
        chk("t2_lat_valid", bus.byte_valid, 0);
        chk("t2_lat_count", bus.count, 1);
        for (int k = 0; k < NB; k++) begin
            tick();
            chk("t2_valid", bus.byte_valid, 1);
            chk("t2_data", bus.byte_data, e2[k]);
        end
        tick();
        chk("t2_end_valid", bus.byte_valid, 0);
        chk("t2_end_count", bus.count, 0);

        bus.byte_ready = 1'b0;
        bus.out_data   = 24'h02BF20;
        bus.out_flag   = 1'b1;
        tick();
        bus.out_flag = 1'b0;
        tick();
        chk("t3_valid", bus.byte_valid, 1);
        chk("t3_data", bus.byte_data, 8'h02);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", bus.byte_valid, 1);
            chk("t3_hold_data", bus.byte_data, 8'h02);
        end
        bus.byte_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            chk("t3_data_seq", bus.byte_data, e3[k]);
            tick();
        end
        chk("t3_end_valid", bus.byte_valid, 0);

        bus.byte_ready = 1'b0;
        for (int w = 1; w <= 10; w++) begin
            bus.out_data = 24'(w);
            bus.out_flag = 1'b1;
            tick();
        end
        bus.out_flag = 1'b0;
        chk("t4_count", bus.count, 8);
        chk("t4_overflow", bus.overflow, 1);
        chk("t4_valid", bus.byte_valid, 1);
        seen.delete();
        h0 = hs_cnt;
        bus.byte_ready = 1'b1;
        repeat (9 * NB + 4) tick();
        chk("t4_bytes", hs_cnt - h0, 9 * NB);
        chk("t4_seen", seen.size(), 9 * NB);
        chk("t4_first_word", seen[BYTES-1], 8'h01);
        chk("t4_last_word", seen[8*NB+BYTES-1], 8'h09);
        chk("t4_end_valid", bus.byte_valid, 0);
        chk("t4_end_count", bus.count, 0);
        chk("t4_ovf_sticky", bus.overflow, 1);

        bus.out_data = 24'hABCDEF;
        bus.out_flag = 1'b1;
        tick();
        bus.out_flag = 1'b0;
        tick();
        tick();
        bus.byte_ready = 1'b0;
        chk("t5_mid_valid", bus.byte_valid, 1);
        chk("t5_mid_data", bus.byte_data, 8'hCD);
        reset = 1'b1;
        tick();
        chk("t5_valid", bus.byte_valid, 0);
        chk("t5_count", bus.count, 0);
        chk("t5_start_io", bus.start_io, 0);
        chk("t5_overflow", bus.overflow, 0);
        chk("t5_data", bus.byte_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t5_idle", bus.start_io, 0);
        end

        bus.byte_ready = 1'b1;
        bus.out_data   = 24'h000050;
        bus.out_flag   = 1'b1;
        tick();
        tick();
        bus.out_flag = 1'b0;
        seen.delete();
        h0 = hs_cnt;
        repeat (2 * NB) tick();
        chk("t6_gapless", hs_cnt - h0, 2 * NB);
        for (int k = 0; k < 2 * NB; k++) chk("t6_data", seen[k], e6[k % NB]);
        tick();
        chk("t6_end_valid", bus.byte_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
